// File: rtl/sr_pulse_gen_if.sv
// Request/response bundle between a request source and the SR latch front-end.
// The master raises raw requests; the slave returns the latch drive pulses and busy.
interface sr_pulse_gen_if;
  logic set_req;
  logic clr_req;
  logic Sbar;
  logic Rbar;
  logic busy;

  modport master (
    output set_req,
    output clr_req,
    input  Sbar,
    input  Rbar,
    input  busy
  );

  modport slave (
    input  set_req,
    input  clr_req,
    output Sbar,
    output Rbar,
    output busy
  );
endinterface

// File: rtl/sr_pulse_gen.sv
// Synchronise and debounce raw set/clear requests, then drive one timed,
// mutually exclusive active-low pulse on Sbar or Rbar per debounced rising edge.
module sr_pulse_gen #(
  parameter int DB_CNT    = 4,
  parameter int PULSE_LEN = 2,
  parameter int GAP_LEN   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  sr_pulse_gen_if.slave sr_if
);

  localparam int DB_W   = $clog2(DB_CNT + 1);
  localparam int TM_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int TM_W   = $clog2(TM_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SET_P = 2'd1,
    ST_CLR_P = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Channel index 0 is the set request, index 1 the clear request.
  logic [1:0] w_raw;
  logic [1:0] w_pend;
  logic [1:0] w_serve;

  assign w_raw = {sr_if.clr_req, sr_if.set_req};

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic            r_s1;
    logic            r_s2;
    logic            r_db;
    logic            r_pend;
    logic [DB_W-1:0] r_cnt;
    logic            w_flip;

    assign w_flip = (r_s2 != r_db) && (r_cnt == DB_W'(DB_CNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1   <= 1'b0;
        r_s2   <= 1'b0;
        r_db   <= 1'b0;
        r_cnt  <= '0;
        r_pend <= 1'b0;
      end else begin
        r_s1 <= w_raw[gi];
        r_s2 <= r_s1;
        if (r_s2 == r_db) begin
          r_cnt <= '0;
        end else if (w_flip) begin
          r_db  <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + DB_W'(1);
        end
        // A fresh rising edge wins over a same-cycle serve so it is never lost.
        r_pend <= (r_pend & ~w_serve[gi]) | (w_flip & r_s2);
      end
    end

    assign w_pend[gi] = r_pend;
  end

  state_t          r_state;
  state_t          w_state_next;
  logic [TM_W-1:0] r_tmr;
  logic [TM_W-1:0] w_tmr_next;
  logic            r_sbar;
  logic            r_rbar;
  logic            w_sbar_next;
  logic            w_rbar_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
      r_sbar  <= 1'b1;
      r_rbar  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_tmr   <= w_tmr_next;
      r_sbar  <= w_sbar_next;
      r_rbar  <= w_rbar_next;
    end
  end

  // Outputs default high; only the pulse states can pull exactly one of them low.
  always_comb begin
    w_state_next = r_state;
    w_tmr_next   = r_tmr;
    w_sbar_next  = 1'b1;
    w_rbar_next  = 1'b1;
    w_serve      = 2'b00;
    case (r_state)
      ST_IDLE: begin
        w_tmr_next = '0;
        if (w_pend[1]) begin
          w_state_next = ST_CLR_P;
          w_rbar_next  = 1'b0;
          w_serve[1]   = 1'b1;
        end else if (w_pend[0]) begin
          w_state_next = ST_SET_P;
          w_sbar_next  = 1'b0;
          w_serve[0]   = 1'b1;
        end
      end
      ST_SET_P: begin
        if (r_tmr == TM_W'(PULSE_LEN - 1)) begin
          w_state_next = ST_GAP;
          w_tmr_next   = '0;
        end else begin
          w_tmr_next  = r_tmr + TM_W'(1);
          w_sbar_next = 1'b0;
        end
      end
      ST_CLR_P: begin
        if (r_tmr == TM_W'(PULSE_LEN - 1)) begin
          w_state_next = ST_GAP;
          w_tmr_next   = '0;
        end else begin
          w_tmr_next  = r_tmr + TM_W'(1);
          w_rbar_next = 1'b0;
        end
      end
      ST_GAP: begin
        if (r_tmr == TM_W'(GAP_LEN - 1)) begin
          w_state_next = ST_IDLE;
          w_tmr_next   = '0;
        end else begin
          w_tmr_next = r_tmr + TM_W'(1);
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_tmr_next   = '0;
      end
    endcase
  end

  assign sr_if.Sbar = r_sbar;
  assign sr_if.Rbar = r_rbar;
  assign sr_if.busy = (r_state != ST_IDLE) | (|w_pend);

endmodule
